// File: rtl/store_narrow_serializer_pkg.sv
// Shared encodings for the store narrowing serializer: access sizes,
// FSM states and the byte count of each access size.
package store_pkg;

  localparam logic [1:0] SZ_BYTE = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_WORD = 2'b10;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    SEND = 2'b01,
    DONE = 2'b10,
    ERR  = 2'b11
  } state_t;

  // Number of bytes written for a size code; 0 marks the illegal encoding.
  function automatic logic [2:0] bytes_of(input logic [1:0] size);
    case (size)
      SZ_BYTE: bytes_of = 3'd1;
      SZ_HALF: bytes_of = 3'd2;
      SZ_WORD: bytes_of = 3'd4;
      default: bytes_of = 3'd0;
    endcase
  endfunction

endpackage

// File: rtl/narrow_fit_check.sv
// Combinational legality and fit check for a store.
// trunc_ovf: the narrowed value would not sign-extend back to data, so
// extend(narrow(data)) == data exactly when trunc_ovf is low.
// misalign: the request must be rejected (unaligned half/word or illegal size).
module narrow_fit_check
  import store_pkg::*;
(
  input  logic [31:0] data,
  input  logic [1:0]  size,
  input  logic [1:0]  addr_lo,
  output logic        trunc_ovf,
  output logic        misalign
);

  // Compare the discarded upper bits against the sign bit of the kept part.
  always_comb begin
    trunc_ovf = 1'b0;
    misalign  = 1'b0;
    case (size)
      SZ_BYTE: trunc_ovf = (data[31:8] != {24{data[7]}});
      SZ_HALF: begin
        trunc_ovf = (data[31:16] != {16{data[15]}});
        misalign  = addr_lo[0];
      end
      SZ_WORD: misalign = (addr_lo != 2'b00);
      default: misalign = 1'b1;
    endcase
  end

endmodule

// File: rtl/store_narrow_serializer.sv
// Store-path serializer: accepts a 32-bit store request, narrows it to the
// requested size and writes it little-endian one byte per acked cycle.
//
// Handshakes: a request transfers on a cycle where req_valid_i && req_ready_o;
// the requester holds it until then. A memory byte transfers on a cycle
// where mem_we_o && mem_ack_i; address and data stay stable until then.
module store_narrow_serializer
  import store_pkg::*;
#(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
)
(
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              req_valid_i,
  output logic              req_ready_o,
  input  logic [ADDR_W-1:0] addr_i,
  input  logic [DATA_W-1:0] data_i,
  input  logic [1:0]        size_i,
  output logic              mem_we_o,
  output logic [ADDR_W-1:0] mem_addr_o,
  output logic [7:0]        mem_data_o,
  input  logic              mem_ack_i,
  output logic              done_o,
  output logic              trunc_ovf_o,
  output logic              err_o
);

  state_t            state;
  logic              live;     // low in reset, high from the first edge after release
  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] data_q;
  logic [1:0]        size_q;
  logic [1:0]        idx;
  logic [1:0]        last;

  logic [DATA_W-1:0] fit_data;
  logic [1:0]        fit_size;
  logic [1:0]        fit_addr_lo;
  logic              fit_trunc;
  logic              fit_misalign;
  logic              accept;

  // In IDLE the checker judges the incoming request; afterwards it reports
  // on the captured store, which is what DONE needs for trunc_ovf_o.
  always_comb begin
    if (state == IDLE) begin
      fit_data    = data_i;
      fit_size    = size_i;
      fit_addr_lo = addr_i[1:0];
    end else begin
      fit_data    = data_q;
      fit_size    = size_q;
      fit_addr_lo = addr_q[1:0];
    end
  end

  narrow_fit_check u_fit (
    .data      (fit_data),
    .size      (fit_size),
    .addr_lo   (fit_addr_lo),
    .trunc_ovf (fit_trunc),
    .misalign  (fit_misalign)
  );

  assign req_ready_o = live && (state == IDLE);
  assign accept      = req_valid_i && req_ready_o;

  // Output decode from registered state; everything is 0 outside its state.
  always_comb begin
    mem_we_o    = (state == SEND);
    mem_addr_o  = '0;
    mem_data_o  = '0;
    done_o      = (state == DONE);
    err_o       = (state == ERR);
    trunc_ovf_o = (state == DONE) && fit_trunc;
    if (state == SEND) begin
      mem_addr_o = addr_q + ADDR_W'(idx);
      mem_data_o = data_q[{idx, 3'b000} +: 8];
    end
  end

  // Request capture and byte sequencing FSM; reset abandons any store in flight.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state  <= IDLE;
      live   <= 1'b0;
      addr_q <= '0;
      data_q <= '0;
      size_q <= '0;
      idx    <= '0;
      last   <= '0;
    end else begin
      live <= 1'b1;
      case (state)
        IDLE: begin
          if (accept) begin
            addr_q <= addr_i;
            data_q <= data_i;
            size_q <= size_i;
            idx    <= '0;
            last   <= 2'(bytes_of(size_i) - 3'd1);
            state  <= fit_misalign ? ERR : SEND;
          end
        end
        SEND: begin
          if (mem_ack_i) begin
            if (idx == last) state <= DONE;
            else             idx   <= idx + 2'd1;
          end
        end
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule
